signed_div_sequencer: RTL

//  Multi-cycle signed integer divider: the sequential stage around the restoring-division step.
//  - Latches the operands, converts them to magnitudes and feeds one restoring step per clock.
//  - Captures each step's partial remainder and quotient, then applies sign correction.
//  - Presents quotient and remainder with a start/busy/done handshake to the datapath.

---
 rtl/signed_div_sequencer_if.sv | 24 ++
 rtl/signed_div_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/signed_div_sequencer_if.sv
// Handshake and operand/result bundle for signed_div_sequencer.
// master drives requests, slave is the divider.
interface signed_div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/signed_div_sequencer.sv
// Multi-cycle signed restoring divider: IDLE -> RUN (WIDTH steps) -> FIX -> DONE.
// Optional SIGNED_DIV_ZERO_FASTPATH_EN skips RUN/FIX when the divisor is zero.
module signed_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  signed_div_sequencer_if.slave bus
);
  localparam int unsigned MW = WIDTH + 1;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state,     state_nxt;
  logic [CW-1:0]    count,     count_nxt;
  logic [WIDTH-1:0] rem,       rem_nxt;
  logic [WIDTH-1:0] q,         q_nxt;
  logic [MW-1:0]    dvs,       dvs_nxt;
  logic             sign_q,    sign_q_nxt;
  logic             sign_r,    sign_r_nxt;
  logic             dz_pend,   dz_pend_nxt;
  logic             busy,      busy_nxt;
  logic             done,      done_nxt;
  logic [WIDTH-1:0] quotient,  quotient_nxt;
  logic [WIDTH-1:0] remainder, remainder_nxt;
  logic             dz,        dz_nxt;
  logic [MW-1:0]    rem_sh;
  logic [WIDTH-1:0] q_sh;

  // Two's-complement magnitude, one bit wider so the most negative value is exact.
  function automatic logic [MW-1:0] mag(input logic [WIDTH-1:0] x);
    logic [MW-1:0] ext;
    ext = {x[WIDTH-1], x};
    return x[WIDTH-1] ? (~ext + MW'(1)) : ext;
  endfunction

  assign rem_sh = {rem, q[WIDTH-1]};
  assign q_sh   = {q[WIDTH-2:0], 1'b0};

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    rem_nxt       = rem;
    q_nxt         = q;
    dvs_nxt       = dvs;
    sign_q_nxt    = sign_q;
    sign_r_nxt    = sign_r;
    dz_pend_nxt   = dz_pend;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    dz_nxt        = dz;

    case (state)
      IDLE: begin
        if (bus.start) begin
          q_nxt       = WIDTH'(mag(bus.dividend));
          dvs_nxt     = mag(bus.divisor);
          rem_nxt     = '0;
          sign_q_nxt  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          sign_r_nxt  = bus.dividend[WIDTH-1];
          dz_pend_nxt = (bus.divisor == '0);
          count_nxt   = CW'(WIDTH - 1);
          busy_nxt    = 1'b1;
          dz_nxt      = 1'b0;
          state_nxt   = RUN;
`ifdef SIGNED_DIV_ZERO_FASTPATH_EN
          if (bus.divisor == '0) begin
            quotient_nxt  = '1;
            remainder_nxt = bus.dividend;
            state_nxt     = DONE;
          end
`endif
        end
      end
      RUN: begin
        // One restoring step: trial-subtract the divisor from the shifted remainder.
        if (rem_sh >= dvs) begin
          rem_nxt = WIDTH'(rem_sh - dvs);
          q_nxt   = {q_sh[WIDTH-1:1], 1'b1};
        end else begin
          rem_nxt = WIDTH'(rem_sh);
          q_nxt   = q_sh;
        end
        count_nxt = count - CW'(1);
        if (count == '0) state_nxt = FIX;
      end
      FIX: begin
        if (dz_pend) quotient_nxt = '1;
        else         quotient_nxt = sign_q ? (~q + WIDTH'(1)) : q;
        remainder_nxt = sign_r ? (~rem + WIDTH'(1)) : rem;
        state_nxt     = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        dz_nxt    = dz_pend;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      rem       <= '0;
      q         <= '0;
      dvs       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dz_pend   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      rem       <= rem_nxt;
      q         <= q_nxt;
      dvs       <= dvs_nxt;
      sign_q    <= sign_q_nxt;
      sign_r    <= sign_r_nxt;
      dz_pend   <= dz_pend_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      quotient  <= quotient_nxt;
      remainder <= remainder_nxt;
      dz        <= dz_nxt;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = dz;
endmodule
